// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field widths, constants, flag indices,
// divider state encoding and operand-class encoding.
package fpu_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    localparam int unsigned FLG_INV = 3;
    localparam int unsigned FLG_DZ  = 2;
    localparam int unsigned FLG_OVF = 1;
    localparam int unsigned FLG_UNF = 0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_UNPACK = 3'd1;
    localparam logic [2:0] ST_DIVIDE = 3'd2;
    localparam logic [2:0] ST_ROUND  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] CLS_ZERO = 2'd0;
    localparam logic [1:0] CLS_NORM = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

endpackage

// File: rtl/fp32_div_iter_if.sv
// Start/busy/done handshake and operand/result bus of the FP32 divider.
interface fp32_div_iter_if;

    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic [3:0]  flags;

    modport master (output start, in1, in2, input busy, done, out, flags);
    modport slave  (input start, in1, in2, output busy, done, out, flags);

endinterface

// File: rtl/fp32_unpack.sv
// Combinational FP32 field extraction and classification.
// Exponent zero (denormals included) is classified as ZERO.
module fp32_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]       i_op,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [FRAC_W:0]   o_sig,
    output logic [1:0]        o_cls
);

    // Split fields, attach hidden one and classify the operand.
    always_comb begin
        o_sign = i_op[31];
        o_exp  = i_op[30:23];
        o_sig  = {1'b1, i_op[22:0]};
        if (i_op[30:23] == '0)
            o_cls = CLS_ZERO;
        else if (i_op[30:23] == '1)
            o_cls = (i_op[22:0] == '0) ? CLS_INF : CLS_NAN;
        else
            o_cls = CLS_NORM;
    end

endmodule

// File: rtl/fp32_div_iter.sv
// Iterative FP32 divider (out = in1 / in2), restoring recurrence,
// RADIX_BITS quotient bits per cycle, RNE rounding, flush-to-zero.
module fp32_div_iter
    import fpu_pkg::*;
#(
    parameter int unsigned RADIX_BITS = 1
)(
    input  logic            clk,
    input  logic            rst_n,
    fp32_div_iter_if.slave  bus
);

    localparam int unsigned ITER = 26 / RADIX_BITS;

    logic [2:0]        r_state;
    logic [31:0]       r_a, r_b;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [23:0]       r_div;
    logic [24:0]       r_rem;
    logic [25:0]       r_q;
    logic [4:0]        r_cnt;
    logic [31:0]       r_out;
    logic [3:0]        r_flags;

    logic              w_sa, w_sb;
    logic [7:0]        w_ea, w_eb;
    logic [23:0]       w_ma, w_mb;
    logic [1:0]        w_ca, w_cb;
    logic              w_shift;
    logic signed [9:0] w_e0;
    logic [24:0]       w_rem0;
    logic              w_special;
    logic [31:0]       w_spec_out;
    logic [3:0]        w_spec_flags;
    logic [24:0]       w_rem_nx;
    logic [25:0]       w_q_nx;
    logic              w_inc;
    logic [24:0]       w_sig;
    logic signed [9:0] w_exp_r;
    logic [22:0]       w_frac;
    logic [31:0]       w_rnd_out;
    logic [3:0]        w_rnd_flags;

    fp32_unpack u_unpack_a (.i_op(r_a), .o_sign(w_sa), .o_exp(w_ea), .o_sig(w_ma), .o_cls(w_ca));
    fp32_unpack u_unpack_b (.i_op(r_b), .o_sign(w_sb), .o_exp(w_eb), .o_sig(w_mb), .o_cls(w_cb));

    // Exponent difference and pre-normalisation so the quotient lands in [1,2).
    always_comb begin
        w_shift = (w_ma < w_mb);
        w_e0    = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'(EXP_BIAS)
                  - (w_shift ? 10'sd1 : 10'sd0);
        w_rem0  = w_shift ? {w_ma, 1'b0} : {1'b0, w_ma};
    end

    // Special-operand resolution; NaN and indeterminate forms take priority.
    always_comb begin
        w_special    = 1'b1;
        w_spec_out   = '0;
        w_spec_flags = '0;
        if (w_ca == CLS_NAN || w_cb == CLS_NAN ||
            (w_ca == CLS_ZERO && w_cb == CLS_ZERO) ||
            (w_ca == CLS_INF && w_cb == CLS_INF)) begin
            w_spec_out            = QNAN;
            w_spec_flags[FLG_INV] = 1'b1;
        end else if (w_cb == CLS_ZERO) begin
            w_spec_out           = {w_sa ^ w_sb, 8'hFF, 23'h0};
            w_spec_flags[FLG_DZ] = 1'b1;
        end else if (w_ca == CLS_INF) begin
            w_spec_out = {w_sa ^ w_sb, 8'hFF, 23'h0};
        end else if (w_ca == CLS_ZERO || w_cb == CLS_INF) begin
            w_spec_out = {w_sa ^ w_sb, 31'h0};
        end else begin
            w_special = 1'b0;
        end
    end

    // One cycle of the restoring recurrence, RADIX_BITS digits deep.
    always_comb begin
        w_rem_nx = r_rem;
        w_q_nx   = r_q;
        for (int unsigned i = 0; i < RADIX_BITS; i++) begin
            if (w_rem_nx >= {1'b0, r_div}) begin
                w_rem_nx = w_rem_nx - {1'b0, r_div};
                w_q_nx   = {w_q_nx[24:0], 1'b1};
            end else begin
                w_q_nx   = {w_q_nx[24:0], 1'b0};
            end
            w_rem_nx = {w_rem_nx[23:0], 1'b0};
        end
    end

    // RNE on guard/round/sticky, renormalise on carry-out, range-check exponent.
    always_comb begin
        w_inc       = r_q[1] & (r_q[0] | (r_rem != '0) | r_q[2]);
        w_sig       = {1'b0, r_q[25:2]} + {24'h0, w_inc};
        w_exp_r     = r_exp + (w_sig[24] ? 10'sd1 : 10'sd0);
        w_frac      = w_sig[24] ? w_sig[23:1] : w_sig[22:0];
        w_rnd_flags = '0;
        if (w_exp_r >= 10'sd255) begin
            w_rnd_out             = {r_sign, 8'hFF, 23'h0};
            w_rnd_flags[FLG_OVF]  = 1'b1;
        end else if (w_exp_r <= 10'sd0) begin
            w_rnd_out             = {r_sign, 31'h0};
            w_rnd_flags[FLG_UNF]  = 1'b1;
        end else begin
            w_rnd_out = {r_sign, w_exp_r[7:0], w_frac};
        end
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.in1;
                        r_b     <= bus.in2;
                        r_state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    r_sign <= w_sa ^ w_sb;
                    if (w_special) begin
                        r_out   <= w_spec_out;
                        r_flags <= w_spec_flags;
                        r_state <= ST_DONE;
                    end else begin
                        r_exp   <= w_e0;
                        r_div   <= w_mb;
                        r_rem   <= w_rem0;
                        r_q     <= '0;
                        r_cnt   <= 5'(ITER - 1);
                        r_state <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    r_rem <= w_rem_nx;
                    r_q   <= w_q_nx;
                    if (r_cnt == '0)
                        r_state <= ST_ROUND;
                    else
                        r_cnt <= r_cnt - 5'd1;
                end
                ST_ROUND: begin
                    r_out   <= w_rnd_out;
                    r_flags <= w_rnd_flags;
                    r_state <= ST_DONE;
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.done  = (r_state == ST_DONE);
    assign bus.out   = r_out;
    assign bus.flags = r_flags;

endmodule

// File: tb/tb_fp32_div_iter.sv
// Self-checking bench for fp32_div_iter: vector table with a scoreboard,
// plus hand-written restart-ignore and reset-abort sequences.
module tb_fp32_div_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp32_div_iter_if bus1();
    fp32_div_iter_if bus2();

    fp32_div_iter #(.RADIX_BITS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    fp32_div_iter #(.RADIX_BITS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          unit;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int u, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (u == 1) begin
            bus1.start = s; bus1.in1 = a; bus1.in2 = b;
        end else begin
            bus2.start = s; bus2.in1 = a; bus2.in2 = b;
        end
    endtask

    function automatic logic get_busy(input int u);
        return (u == 1) ? bus1.busy : bus2.busy;
    endfunction

    function automatic logic get_done(input int u);
        return (u == 1) ? bus1.done : bus2.done;
    endfunction

    function automatic logic [31:0] get_out(input int u);
        return (u == 1) ? bus1.out : bus2.out;
    endfunction

    function automatic logic [3:0] get_flags(input int u);
        return (u == 1) ? bus1.flags : bus2.flags;
    endfunction

    // Called #1 after a rising edge. Optionally pulses start with other operands mid-operation.
    task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [3:0] f, input int lat,
                          input string nm, input bit inj);
        exp_t e;
        int   cnt;
        bit   got;
        bit   busy_bad;
        e.name = nm; e.q = q; e.f = f; e.lat = lat;
        sb.push_back(e);
        drive(u, 1'b1, a, b);
        cnt = 0; got = 0; busy_bad = 0;
        while (!got && cnt < 80) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) drive(u, 1'b0, a, b);
            if (inj && cnt == 5) drive(u, 1'b1, 32'h3F80_0000, 32'h4040_0000);
            if (inj && cnt == 6) drive(u, 1'b0, a, b);
            if (!get_busy(u)) busy_bad = 1;
            if (get_done(u)) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done after %0d cycles, required at %0d", nm, cnt, lat);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard: done with empty scoreboard", nm);
            return;
        end
        e = sb.pop_front();
        check({e.name, "_out"},   get_out(u),           e.q);
        check({e.name, "_flags"}, 32'(get_flags(u)),    32'(e.f));
        check({e.name, "_lat"},   32'(cnt),             32'(e.lat));
        check({e.name, "_busy"},  32'(busy_bad),        32'h0);
        @(posedge clk); #1;
        check({e.name, "_idle"},  {30'h0, get_busy(u), get_done(u)}, 32'h0);
        check({e.name, "_held"},  get_out(u),           e.q);
    endtask

    initial begin
        int   cnt;
        bit   done_seen;

        vecs.push_back('{"div6_2",     1, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29});
        vecs.push_back('{"div1_3",     1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29});
        vecs.push_back('{"divm1_3",    1, 32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 4'b0000, 29});
        vecs.push_back('{"x_by_0",     1, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2});
        vecs.push_back('{"zero_zero",  1, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2});
        vecs.push_back('{"inf_inf",    1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2});
        vecs.push_back('{"denorm_ftz", 1, 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 2});
        vecs.push_back('{"overflow",   1, 32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 4'b0010, 29});
        vecs.push_back('{"underflow",  1, 32'h00800000, 32'h41000000, 32'h00000000, 4'b0001, 29});
        vecs.push_back('{"nan_in",     1, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2});
        vecs.push_back('{"inf_negfin", 1, 32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 2});
        vecs.push_back('{"fin_neginf", 1, 32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 2});
        vecs.push_back('{"negneg",     1, 32'hC0C00000, 32'hC0000000, 32'h40400000, 4'b0000, 29});
        vecs.push_back('{"equal",      1, 32'h3FC00000, 32'h3FC00000, 32'h3F800000, 4'b0000, 29});
        vecs.push_back('{"r2_div1_3",  2, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 16});
        vecs.push_back('{"r2_div6_2",  2, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 16});
        vecs.push_back('{"r2_ovf",     2, 32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 4'b0010, 16});

        rst_n = 1'b0;
        drive(1, 1'b0, '0, '0);
        drive(2, 1'b0, '0, '0);
        #12;
        for (int u = 1; u <= 2; u++) begin
            check($sformatf("reset_out_u%0d", u),   get_out(u),          32'h0);
            check($sformatf("reset_flags_u%0d", u), 32'(get_flags(u)),   32'h0);
            check($sformatf("reset_ctl_u%0d", u),   {30'h0, get_busy(u), get_done(u)}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].unit, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f, vecs[i].lat, vecs[i].name, 1'b0);

        // Second start mid-DIVIDE must be ignored.
        run_op(1, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, "restart_ignored", 1'b1);

        // Back-to-back: issue in the IDLE cycle straight after the previous op.
        run_op(1, 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2, "b2b_dz", 1'b0);
        run_op(1, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, "b2b_div", 1'b0);

        // Reset at cycle 10 of an operation aborts it; out holds 40400000 beforehand.
        drive(1, 1'b1, 32'h3F800000, 32'h40400000);
        cnt = 0;
        done_seen = 0;
        while (cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) drive(1, 1'b0, 32'h3F800000, 32'h40400000);
            if (bus1.done) done_seen = 1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_out",   bus1.out,          32'h0);
        check("abort_flags", 32'(bus1.flags),   32'h0);
        check("abort_busy",  32'(bus1.busy),    32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            if (bus1.done) done_seen = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus1.done || bus1.busy) done_seen = 1;
        end
        check("abort_no_done", 32'(done_seen), 32'h0);

        run_op(1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29, "after_reset", 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
